adiabatic_phase_ctrl: RTL

ADIABATIC_PHASE_CTRL -- requirements
Module: adiabatic_phase_ctrl

---
 rtl/adiabatic_phase_ctrl_if.sv | 34 +++
 rtl/adiabatic_phase_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/adiabatic_phase_ctrl_if.sv
// Handshake and power-clock bundle between the op requester
// and the adiabatic two-stage phase sequencer.
interface adiabatic_phase_ctrl_if;
    logic       en;
    logic       op_valid;
    logic       op_ready;
    logic       op_issue;
    logic [3:0] lvl1;
    logic [3:0] lvl2;
    logic       clkpos1;
    logic       clkneg1;
    logic       clkpos2;
    logic       clkneg2;
    logic       res_valid;
    logic       busy;

    modport master (
        output en, op_valid,
        input  op_ready, op_issue,
        input  lvl1, lvl2,
        input  clkpos1, clkneg1,
        input  clkpos2, clkneg2,
        input  res_valid, busy
    );

    modport slave (
        input  en, op_valid,
        output op_ready, op_issue,
        output lvl1, lvl2,
        output clkpos1, clkneg1,
        output clkpos2, clkneg2,
        output res_valid, busy
    );
endinterface

// File: rtl/adiabatic_phase_ctrl.sv
// Two-stage adiabatic power-clock sequencer: trapezoidal
// step-charger levels, stage 2 lagging stage 1 by NSTEP.
module adiabatic_phase_ctrl #(
    parameter int NSTEP = 4,
    parameter int HOLD  = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    adiabatic_phase_ctrl_if.slave bus
);
    localparam int P  = 2 * NSTEP + 2 * HOLD;
    localparam int CW = 6;

    localparam logic [CW-1:0] C_LAST  = CW'(P - 1);
    localparam logic [CW-1:0] C_NM1   = CW'(NSTEP - 1);
    localparam logic [CW-1:0] C_NSTEP = CW'(NSTEP);
    localparam logic [CW-1:0] C_HEND  = CW'(NSTEP + HOLD);
    localparam logic [CW-1:0] C_FEND  = CW'(2 * NSTEP + HOLD);
    localparam logic [CW-1:0] C_FTOP  = CW'(2 * NSTEP + HOLD - 1);
    localparam logic [CW-1:0] C_LAG   = CW'(P - NSTEP);
    localparam logic [CW-1:0] C_RES   = CW'(NSTEP + HOLD - 1);
    localparam logic [3:0]    L_TOP   = 4'(NSTEP);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          fire1;
    logic          fire2;
    logic          armed;
    logic [CW-1:0] k2;
    logic          ready;
    logic          accept;
    logic [3:0]    l1;
    logic [3:0]    l2;

    function automatic logic [3:0] wave(input logic [CW-1:0] k);
        logic [3:0] l;
        l = '0;
        unique case (1'b1)
            (k < C_NSTEP):
                l = 4'(k + 1'b1);
            (k >= C_NSTEP && k < C_HEND):
                l = L_TOP;
            (k >= C_HEND && k < C_FEND):
                l = 4'(C_FTOP - k);
            (k >= C_FEND):
                l = '0;
        endcase
        return l;
    endfunction

    // stage-2 phase position, cnt delayed by NSTEP modulo P
    always_comb begin
        k2 = cnt + C_LAG;
        if (cnt >= C_NSTEP)
            k2 = cnt - C_NSTEP;
    end

    // armed keeps op_ready low until the first edge after reset
    always_comb begin
        ready = 1'b0;
        if (state == IDLE)
            ready = bus.en & armed;
        else
            ready = bus.en & (cnt == C_LAST);
    end

    assign accept = bus.op_valid & ready;

    assign l1 = fire1 ? wave(cnt) : 4'd0;
    assign l2 = fire2 ? wave(k2) : 4'd0;

    assign bus.op_ready  = ready;
    assign bus.op_issue  = accept;
    assign bus.lvl1      = l1;
    assign bus.lvl2      = l2;
    assign bus.clkpos1   = (l1 == L_TOP);
    assign bus.clkneg1   = (l1 == 4'd0);
    assign bus.clkpos2   = (l2 == L_TOP);
    assign bus.clkneg2   = (l2 == 4'd0);
    assign bus.res_valid = fire2 & (k2 == C_RES);
    assign bus.busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            fire1 <= 1'b0;
            fire2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    cnt   <= '0;
                    fire2 <= 1'b0;
                    if (accept) begin
                        state <= RUN;
                        fire1 <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == C_NM1)
                        fire2 <= fire1;
                    if (cnt == C_LAST) begin
                        cnt <= '0;
                        if (accept) begin
                            fire1 <= 1'b1;
                        end else begin
                            fire1 <= 1'b0;
                            // stage 2 already retired its last op
                            if (!fire1) begin
                                state <= IDLE;
                                fire2 <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
